uart_mmio: RTL and testbench

Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a runtime-programmable baud divisor, sticky error flags and an interrupt output. It sits on the core data bus beside the data memory. The top-level read mux selects this block's read_data whenever sel is high. It contains its own serializer and deserializer, and tx/rx connect directly to pins.

---
 rtl/uart_mmio_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 70 +++++++
 rtl/uart_mmio.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared constants and state type for the memory-mapped UART
package uart_mmio_pkg;

    // Register offsets, word index taken from address[3:2]
    localparam logic [1:0] OFS_DATA   = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_DIV    = 2'd2;
    localparam logic [1:0] OFS_CTRL   = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_RX_FULL   = 1;
    localparam int ST_TX_FULL   = 2;
    localparam int ST_TX_EMPTY  = 3;
    localparam int ST_TX_BUSY   = 4;
    localparam int ST_RX_OVR    = 5;
    localparam int ST_FRAME_ERR = 6;
    localparam int ST_TX_OVF    = 7;

    // CTRL bit positions and reset value (tx_en and rx_en on, interrupts off)
    localparam int CTRL_TX_EN = 0;
    localparam int CTRL_RX_EN = 1;
    localparam int CTRL_RX_IE = 2;
    localparam int CTRL_TX_IE = 3;
    localparam logic [3:0] CTRL_RESET = 4'b0011;

    // Frame state, shared by the serializer and the deserializer
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with first-word fall-through read port
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, din     write request and data; accepted when not full or when popping
//   pop           read request; ignored when empty
//   dout          current head entry (valid while empty is low)
//   full, empty   occupancy flags
//   count         number of stored entries, 0..DEPTH
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);
    assign dout  = mem[rd_ptr];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped UART with TX/RX FIFOs, baud divisor, sticky errors and irq
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   address         bus byte address; sel decodes address[31:4], offset is address[3:2]
//   write_data      bus write data
//   write_mask      byte enables
//   write_enable    write strobe
//   read_enable     read strobe; a DATA read with this high pops the RX FIFO
//   read_data       combinational register read data
//   sel             high when address falls in this block's 16-byte window
//   tx              serial output, idle high
//   rx              serial input, asynchronous to clk
//   irq             registered level interrupt
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
    parameter int          TX_DEPTH        = 16,
    parameter int          RX_DEPTH        = 16,
    parameter int          DATA_BITS       = 8,
    parameter int          DIV_WIDTH       = 16,
    parameter int          DEFAULT_DIVISOR = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        sel,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0]        LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]        BIT_ONE  = BW'(1);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(4);

    // ---------------- bus decode ----------------
    logic [1:0] offset;
    logic       bus_wr;
    logic       bus_rd;

    assign sel    = (address[31:4] == BASE_ADDR[31:4]);
    assign offset = address[3:2];
    assign bus_wr = sel & write_enable;
    assign bus_rd = sel & read_enable;

    // ---------------- registers ----------------
    logic [DIV_WIDTH-1:0] divisor;
    logic [3:0]           ctrl;
    logic                 rx_ovr;
    logic                 frame_err;
    logic                 tx_ovf;
    logic                 rx_ovr_set;
    logic                 frame_err_set;
    logic                 tx_ovf_set;
    logic                 sticky_clr;
    logic [31:0]          div_merged;
    logic [DIV_WIDTH-1:0] div_next;

    logic tx_en;
    logic rx_en;
    assign tx_en = ctrl[CTRL_TX_EN];
    assign rx_en = ctrl[CTRL_RX_EN];

    // ---------------- FIFOs ----------------
    logic                       tx_push;
    logic                       tx_pop;
    logic                       tx_full;
    logic                       tx_empty;
    logic [DATA_BITS-1:0]       tx_dout;
    logic [$clog2(TX_DEPTH):0]  tx_count;

    logic                       rx_push;
    logic                       rx_pop;
    logic                       rx_full;
    logic                       rx_empty;
    logic [DATA_BITS-1:0]       rx_dout;
    logic [DATA_BITS-1:0]       rx_shift;
    logic [$clog2(RX_DEPTH):0]  rx_count;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (write_data[DATA_BITS-1:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A byte written while the FIFO is full is only lost if the serializer
    // does not free a slot in the same cycle.
    assign tx_push    = bus_wr & (offset == OFS_DATA) & write_mask[0];
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_pop     = bus_rd & (offset == OFS_DATA) & ~rx_empty;
    assign sticky_clr = bus_wr & (offset == OFS_STATUS) & write_mask[0];

    // Byte-lane merge for DIVISOR, then clamp so half-bit timing stays >= 2.
    always_comb begin
        div_merged = 32'(divisor);
        if (write_mask[0]) div_merged[7:0]  = write_data[7:0];
        if (write_mask[1]) div_merged[15:8] = write_data[15:8];
        div_next = div_merged[DIV_WIDTH-1:0];
        if (div_next < MIN_DIV) div_next = MIN_DIV;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor   <= DIV_WIDTH'(DEFAULT_DIVISOR);
            ctrl      <= CTRL_RESET;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            if (bus_wr && offset == OFS_DIV && (write_mask[0] || write_mask[1])) begin
                divisor <= div_next;
            end
            if (bus_wr && offset == OFS_CTRL && write_mask[0]) begin
                ctrl <= write_data[3:0];
            end
            // W1C; a new event in the same cycle as the clear keeps the flag set.
            rx_ovr    <= (rx_ovr    & ~(sticky_clr & write_data[ST_RX_OVR]))    | rx_ovr_set;
            frame_err <= (frame_err & ~(sticky_clr & write_data[ST_FRAME_ERR])) | frame_err_set;
            tx_ovf    <= (tx_ovf    & ~(sticky_clr & write_data[ST_TX_OVF]))    | tx_ovf_set;
        end
    end

    // ---------------- serializer ----------------
    uart_state_t          tx_state;
    logic [DIV_WIDTH-1:0] tx_cnt;
    logic [DIV_WIDTH-1:0] tx_div;
    logic [DATA_BITS-1:0] tx_shift;
    logic [BW-1:0]        tx_bit;
    logic                 tx_last;
    logic                 tx_busy;

    assign tx_busy = (tx_state != IDLE);
    assign tx_last = (tx_cnt == tx_div - ONE);
    // New frame starts from IDLE or straight out of the last STOP cycle.
    assign tx_pop  = tx_en & ~tx_empty &
                     ((tx_state == IDLE) | ((tx_state == STOP) & tx_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_div   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
        end else begin
            if (tx_pop) begin
                tx_state <= START;
                tx_shift <= tx_dout;
                tx_div   <= divisor;
                tx_cnt   <= '0;
                tx       <= 1'b0;
            end else begin
                case (tx_state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (tx_last) begin
                            tx_state <= DATA;
                            tx_cnt   <= '0;
                            tx_bit   <= '0;
                            tx       <= tx_shift[0];
                        end else begin
                            tx_cnt <= tx_cnt + ONE;
                        end
                    end
                    DATA: begin
                        if (tx_last) begin
                            tx_cnt <= '0;
                            if (tx_bit == LAST_BIT) begin
                                tx_state <= STOP;
                                tx       <= 1'b1;
                            end else begin
                                tx_bit   <= tx_bit + BIT_ONE;
                                tx_shift <= tx_shift >> 1;
                                tx       <= tx_shift[1];
                            end
                        end else begin
                            tx_cnt <= tx_cnt + ONE;
                        end
                    end
                    STOP: begin
                        if (tx_last) begin
                            tx_state <= IDLE;
                            tx_cnt   <= '0;
                        end else begin
                            tx_cnt <= tx_cnt + ONE;
                        end
                    end
                    default: tx_state <= IDLE;
                endcase
            end
        end
    end

    // ---------------- deserializer ----------------
    logic [1:0]           rx_sync;
    logic                 rx_s;
    uart_state_t          rx_state;
    logic [DIV_WIDTH-1:0] rx_cnt;
    logic [DIV_WIDTH-1:0] rx_div;
    logic [BW-1:0]        rx_bit;
    logic                 rx_last;
    logic                 rx_half;
    logic                 stop_sample;

    assign rx_s        = rx_sync[1];
    assign rx_last     = (rx_cnt == rx_div - ONE);
    assign rx_half     = (rx_cnt == (rx_div >> 1) - ONE);
    assign stop_sample = (rx_state == STOP) & rx_last;

    assign rx_push       = stop_sample & rx_s & (~rx_full | rx_pop);
    assign rx_ovr_set    = stop_sample & rx_s & rx_full & ~rx_pop;
    assign frame_err_set = stop_sample & ~rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            case (rx_state)
                IDLE: begin
                    if (rx_en && !rx_s) begin
                        rx_state <= START;
                        rx_div   <= divisor;
                        rx_cnt   <= '0;
                    end
                end
                START: begin
                    // Mid-start resample rejects glitches shorter than half a bit.
                    if (rx_half) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
                DATA: begin
                    if (rx_last) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == LAST_BIT) begin
                            rx_state <= STOP;
                        end else begin
                            rx_bit <= rx_bit + BIT_ONE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
                STOP: begin
                    if (rx_last) begin
                        rx_state <= IDLE;
                        rx_cnt   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt + ONE;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // ---------------- read mux and interrupt ----------------
    logic [7:0] status;

    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = ~rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_BUSY]   = tx_busy;
        status[ST_RX_OVR]    = rx_ovr;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_OVF]    = tx_ovf;
    end

    always_comb begin
        read_data = '0;
        case (offset)
            OFS_DATA:   if (!rx_empty) read_data[DATA_BITS-1:0] = rx_dout;
            OFS_STATUS: read_data[7:0] = status;
            OFS_DIV:    read_data[DIV_WIDTH-1:0] = divisor;
            OFS_CTRL:   read_data[3:0] = ctrl;
            default:    read_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (~rx_empty & ctrl[CTRL_RX_IE]) |
                   (tx_empty & ~tx_busy & ctrl[CTRL_TX_IE]);
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, address[1:0], write_data[31:16], write_mask[3:2],
                         div_merged, tx_count, rx_count};

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - scoreboard bench for uart_mmio
module tb_uart_mmio;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] read_data;
    logic        sel;
    logic        tx;
    logic        rx_w;
    logic        irq;
    logic        loop_en;
    logic        rx_drv;

    always #5 clk = ~clk;

    assign rx_w = loop_en ? tx : rx_drv;

    uart_mmio dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .write_data   (write_data),
        .write_mask   (write_mask),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .sel          (sel),
        .tx           (tx),
        .rx           (rx_w),
        .irq          (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_q[$];
    logic [1:0] wave_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb_pop();
        if (sb_q.size() == 0) return 8'hxx;
        return sb_q.pop_front();
    endfunction

    task automatic bus_write_addr(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [3:0] mask);
        @(negedge clk);
        address      = addr;
        write_data   = data;
        write_mask   = mask;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        write_mask   = 4'h0;
    endtask

    task automatic wr(input logic [3:0] ofs, input logic [31:0] data, input logic [3:0] mask);
        bus_write_addr(BASE + 32'(ofs), data, mask);
    endtask

    task automatic rd(input logic [3:0] ofs, input logic pop, output logic [31:0] d);
        @(negedge clk);
        address     = BASE + 32'(ofs);
        read_enable = pop;
        #1 d = read_data;
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    // Drive one 8N1 frame on rx at 4 clocks per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (4) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    // Decode one frame from tx at 4 clocks per bit, sampling mid-bit.
    task automatic tx_decode(output logic [7:0] b, output logic stop_bit, output logic found);
        int waited;
        waited   = 0;
        found    = 1'b0;
        b        = 8'h00;
        stop_bit = 1'b0;
        while (tx !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (tx === 1'b0) begin
            found = 1'b1;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = tx;
            end
            repeat (4) @(negedge clk);
            stop_bit = tx;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic        stop_bit;
        logic        found;
        logic        saw_low;

        rst          = 1'b1;
        address      = BASE;
        write_data   = '0;
        write_mask   = '0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        loop_en      = 1'b0;
        rx_drv       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and decode
        rd(4'h8, 1'b0, d); check("rst_div", d, 32'd434);
        rd(4'hC, 1'b0, d); check("rst_ctrl", d, 32'h3);
        rd(4'h4, 1'b0, d); check("rst_status", d, 32'h08);
        check("rst_tx", tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("sel_in", sel, 1'b1);
        address = 32'h1002_0008;
        #1 check("sel_out", sel, 1'b0);
        bus_write_addr(32'h1002_0008, 32'd9, 4'h3);
        rd(4'h8, 1'b0, d); check("div_unsel", d, 32'd434);
        wr(4'h8, 32'd1, 4'h3);
        rd(4'h8, 1'b0, d); check("div_clamp", d, 32'd4);
        wr(4'h8, 32'h0000_1205, 4'h2);
        rd(4'h8, 1'b0, d); check("div_lane1", d, 32'h1204);
        wr(4'h8, 32'd4, 4'h3);

        // Test 1: single 0x55 frame waveform and tx_busy window
        wave_q.push_back(2'b01);
        repeat (4) wave_q.push_back(2'b10);
        for (int i = 0; i < 8; i++) begin
            b = 8'h55;
            repeat (4) wave_q.push_back({1'b1, b[i]});
        end
        repeat (4) wave_q.push_back(2'b11);
        wave_q.push_back(2'b01);
        wr(4'h0, 32'h55, 4'h1);
        address = BASE + 32'h4;
        for (int i = 0; i < 42; i++) begin
            #1 check("t1_wave", {read_data[4], tx}, wave_q.pop_front());
            @(negedge clk);
        end
        #1 check("t1_tx_empty", read_data[3], 1'b1);

        // Test 2: loopback of two frames, ordered reads, rx irq
        loop_en = 1'b1;
        wr(4'hC, 32'h7, 4'h1);
        sb_q.push_back(8'hA3);
        wr(4'h0, 32'hA3, 4'h1);
        sb_q.push_back(8'h5C);
        wr(4'h0, 32'h5C, 4'h1);
        repeat (120) @(negedge clk);
        rd(4'h4, 1'b0, d); check("t2_rx_avail", d[0], 1'b1);
        check("t2_irq", irq, 1'b1);
        rd(4'h0, 1'b1, d); check("t2_byte0", d, 32'(sb_pop()));
        rd(4'h0, 1'b1, d); check("t2_byte1", d, 32'(sb_pop()));
        rd(4'h0, 1'b1, d); check("t2_empty_read", d, 32'h0);
        rd(4'h4, 1'b0, d); check("t2_rx_avail_0", d[0], 1'b0);
        check("t2_irq_0", irq, 1'b0);
        wr(4'hC, 32'h3, 4'h1);
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        // Test 3: RX overrun with RX_DEPTH+1 frames
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 16) sb_q.push_back(b);
            send_frame(b, 1'b1);
        end
        repeat (10) @(negedge clk);
        rd(4'h4, 1'b0, d);
        check("t3_rx_full", d[1], 1'b1);
        check("t3_rx_ovr", d[5], 1'b1);
        wr(4'h4, 32'h20, 4'h1);
        rd(4'h4, 1'b0, d);
        check("t3_ovr_clr", d[5], 1'b0);
        check("t3_full_kept", d[1], 1'b1);
        for (int i = 0; i < 16; i++) begin
            rd(4'h0, 1'b1, d); check("t3_byte", d, 32'(sb_pop()));
        end
        rd(4'h4, 1'b0, d); check("t3_drained", d & 32'hE3, 32'h0);

        // Test 4: framing error, then a short glitch
        send_frame(8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        rd(4'h4, 1'b0, d); check("t4_frame_err", d & 32'hE3, 32'h40);
        wr(4'h4, 32'h40, 4'h1);
        rd(4'h4, 1'b0, d); check("t4_fe_clr", d & 32'hE3, 32'h0);
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        rd(4'h4, 1'b0, d); check("t4_glitch", d & 32'hE3, 32'h0);

        // Test 5: TX overflow with tx_en off, then drain in order
        wr(4'hC, 32'h2, 4'h1);
        saw_low = 1'b0;
        for (int i = 0; i < 18; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i < 16) sb_q.push_back(b);
            wr(4'h0, 32'(b), 4'h1);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        rd(4'h4, 1'b0, d);
        check("t5_tx_full", d[2], 1'b1);
        check("t5_tx_ovf", d[7], 1'b1);
        check("t5_tx_idle", saw_low, 1'b0);
        wr(4'hC, 32'h3, 4'h1);
        for (int i = 0; i < 16; i++) begin
            tx_decode(b, stop_bit, found);
            check("t5_found", found, 1'b1);
            check("t5_byte", b, sb_pop());
            check("t5_stop", stop_bit, 1'b1);
        end
        saw_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("t5_no_extra", saw_low, 1'b0);
        rd(4'h4, 1'b0, d); check("t5_status", d & 32'h1F, 32'h08);
        wr(4'h4, 32'h80, 4'h1);

        // Test 6: reset in the middle of a frame
        wr(4'h0, 32'h00, 4'h1);
        repeat (12) @(negedge clk);
        check("t6_mid_frame", tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_tx_reset", tx, 1'b1);
        rst = 1'b0;
        rd(4'h8, 1'b0, d); check("t6_div", d, 32'd434);
        rd(4'hC, 1'b0, d); check("t6_ctrl", d, 32'h3);
        rd(4'h4, 1'b0, d); check("t6_status", d, 32'h08);
        check("t6_irq", irq, 1'b0);
        saw_low = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("t6_tx_quiet", saw_low, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
